// File: rtl/mcp3002_spi_responder_pkg.sv
// Shared types and constants for the MCP3002 SPI responder.
package mcp3002_pkg;
  localparam int DATA_W_DEFAULT = 10;

  // Bit positions inside last_cfg
  localparam int CFG_SGL  = 2;
  localparam int CFG_ODD  = 1;
  localparam int CFG_MSBF = 0;

  typedef enum logic [3:0] {
    IDLE, WAIT_START, GET_SGL, GET_ODD, GET_MSBF, NULL, MSB, LSB, ZERO
  } state_t;
endpackage

// File: rtl/mcp3002_spi_responder_pin_sync.sv
// Synchronizes CS, SCK and DIN into sysclk and derives SCK edge strobes.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_sck,
  input  logic i_din,
  output logic o_cs_s,
  output logic o_din_s,
  output logic o_sck_rise,
  output logic o_sck_fall
);
  logic [SYNC_STAGES-1:0] r_cs, r_sck, r_din;
  logic                   r_sck_prev;

  // Synchronizer chains; reset to the idle bus state (CS high, SCK low)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs       <= '1;
      r_sck      <= '0;
      r_din      <= '0;
      r_sck_prev <= 1'b0;
    end else begin
      r_cs       <= {r_cs[SYNC_STAGES-2:0],  i_cs};
      r_sck      <= {r_sck[SYNC_STAGES-2:0], i_sck};
      r_din      <= {r_din[SYNC_STAGES-2:0], i_din};
      r_sck_prev <= r_sck[SYNC_STAGES-1];
    end
  end

  assign o_cs_s     = r_cs[SYNC_STAGES-1];
  assign o_din_s    = r_din[SYNC_STAGES-1];
  assign o_sck_rise =  r_sck[SYNC_STAGES-1] & ~r_sck_prev;
  assign o_sck_fall = ~r_sck[SYNC_STAGES-1] &  r_sck_prev;
endmodule

// File: rtl/mcp3002_spi_responder.sv
// MCP3002 device-side SPI emulation: command decode and serial result return.
module mcp3002_spi_responder
  import mcp3002_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = DATA_W_DEFAULT
) (
  input  logic              i_sysclk,
  input  logic              i_rst,
  input  logic              i_adc_cs,
  input  logic              i_adc_sck,
  input  logic              i_sdata_to_adc,
  input  logic [DATA_W-1:0] i_sample_ch0,
  input  logic [DATA_W-1:0] i_sample_ch1,
  output logic              o_sdata_from_adc,
  output logic              o_dout_oe,
  output logic              o_conv_done,
  output logic              o_frame_abort,
  output logic [2:0]        o_last_cfg
);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

  logic w_cs_s, w_din_s, w_rise, w_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_sysclk),
    .i_rst      (i_rst),
    .i_cs       (i_adc_cs),
    .i_sck      (i_adc_sck),
    .i_din      (i_sdata_to_adc),
    .o_cs_s     (w_cs_s),
    .o_din_s    (w_din_s),
    .o_sck_rise (w_rise),
    .o_sck_fall (w_fall)
  );

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_hold;
  logic              r_sgl, r_odd, r_msbf;
  logic              r_dout, r_oe, r_done, r_abort;
  logic [2:0]        r_cfg;

  // Differential results carry a borrow in the top bit; a borrow clamps to 0
  logic [DATA_W:0]   w_diff01, w_diff10;
  logic [DATA_W-1:0] w_result;
  assign w_diff01 = {1'b0, i_sample_ch0} - {1'b0, i_sample_ch1};
  assign w_diff10 = {1'b0, i_sample_ch1} - {1'b0, i_sample_ch0};

  // Select the conversion value from the command bits received so far
  always_comb begin
    w_result = '0;
    if (r_sgl)       w_result = r_odd ? i_sample_ch1 : i_sample_ch0;
    else if (!r_odd) w_result = w_diff01[DATA_W] ? '0 : w_diff01[DATA_W-1:0];
    else             w_result = w_diff10[DATA_W] ? '0 : w_diff10[DATA_W-1:0];
  end

  // Frame FSM: CS release wins over any same-cycle SCK edge
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
      r_sgl   <= 1'b0;
      r_odd   <= 1'b0;
      r_msbf  <= 1'b0;
      r_dout  <= 1'b0;
      r_oe    <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_cfg   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      if (r_state != IDLE && w_cs_s) begin
        r_state <= IDLE;
        r_dout  <= 1'b0;
        r_oe    <= 1'b0;
        if (r_state inside {NULL, MSB, LSB}) r_abort <= 1'b1;
      end else begin
        case (r_state)
          IDLE:       if (!w_cs_s) r_state <= WAIT_START;
          WAIT_START: if (w_rise && w_din_s) r_state <= GET_SGL;
          GET_SGL: if (w_rise) begin
            r_sgl   <= w_din_s;
            r_state <= GET_ODD;
          end
          GET_ODD: if (w_rise) begin
            r_odd   <= w_din_s;
            r_state <= GET_MSBF;
          end
          GET_MSBF: if (w_rise) begin
            r_msbf          <= w_din_s;
            r_cfg[CFG_SGL]  <= r_sgl;
            r_cfg[CFG_ODD]  <= r_odd;
            r_cfg[CFG_MSBF] <= w_din_s;
            r_hold          <= w_result;
            r_state         <= NULL;
          end
          NULL: if (w_fall) begin
            r_dout  <= 1'b0;
            r_oe    <= 1'b1;
            r_idx   <= IDX_TOP;
            r_state <= MSB;
          end
          MSB: if (w_fall) begin
            r_dout <= r_hold[r_idx];
            if (r_idx == '0) begin
              if (r_msbf) begin
                r_done  <= 1'b1;
                r_state <= ZERO;
              end else begin
                // B0 was just sent; the LSB-first tail restarts at B1
                r_idx   <= IDX_W'(1);
                r_state <= LSB;
              end
            end else begin
              r_idx <= r_idx - 1'b1;
            end
          end
          LSB: if (w_fall) begin
            r_dout <= r_hold[r_idx];
            if (r_idx == IDX_TOP) begin
              r_done  <= 1'b1;
              r_state <= ZERO;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          ZERO: if (w_fall) begin
            r_dout <= 1'b0;
            r_oe   <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_sdata_from_adc = r_dout;
  assign o_dout_oe        = r_oe;
  assign o_conv_done      = r_done;
  assign o_frame_abort    = r_abort;
  assign o_last_cfg       = r_cfg;
endmodule

// File: tb/tb_mcp3002_spi_responder.sv
// Randomized scoreboard bench for mcp3002_spi_responder.
module tb_mcp3002_spi_responder;
  localparam int DW   = 10;
  localparam int HALF = 8;   // sysclk cycles per SCK half period

  logic          clk = 1'b0;
  logic          rst, cs, sck, din;
  logic [DW-1:0] ch0, ch1;
  logic          sdata, oe, done, abrt;
  logic [2:0]    cfg;

  always #5 clk = ~clk;

  mcp3002_spi_responder #(.SYNC_STAGES(2), .DATA_W(DW)) dut (
    .i_sysclk         (clk),
    .i_rst            (rst),
    .i_adc_cs         (cs),
    .i_adc_sck        (sck),
    .i_sdata_to_adc   (din),
    .i_sample_ch0     (ch0),
    .i_sample_ch1     (ch1),
    .o_sdata_from_adc (sdata),
    .o_dout_oe        (oe),
    .o_conv_done      (done),
    .o_frame_abort    (abrt),
    .o_last_cfg       (cfg)
  );

  // kind 0: DOUT sample, 1: end of frame, 2: after reset
  typedef struct {
    int       kind;
    int       dout;
    int       oe;
    int       done;
    int       abrt;
    int       cfg;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   total = 0, bad = 0;
  int   n_done = 0, n_abort = 0;
  int   seen_done = 0, seen_abort = 0;
  int   model_cfg = 0;

  // Pulse counters; a wide pulse counts more than once
  always @(negedge clk) begin
    if (done) n_done++;
    if (abrt) n_abort++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: drains the expectation queue whenever the master presents a check point
  exp_t m;
  always begin
    @(chk_ev);
    while (q.size() > 0) begin
      m = q.pop_front();
      case (m.kind)
        0: begin
          chk("dout", int'(sdata), m.dout);
          chk("dout_oe", int'(oe), m.oe);
        end
        1: begin
          chk("conv_done_cnt", n_done - seen_done, m.done);
          chk("frame_abort_cnt", n_abort - seen_abort, m.abrt);
          chk("last_cfg", int'(cfg), m.cfg);
          chk("end_dout", int'(sdata), 0);
          chk("end_oe", int'(oe), 0);
          seen_done  = n_done;
          seen_abort = n_abort;
        end
        default: begin
          chk("rst_dout", int'(sdata), 0);
          chk("rst_oe", int'(oe), 0);
          chk("rst_done", int'(done), 0);
          chk("rst_abort", int'(abrt), 0);
          chk("rst_cfg", int'(cfg), 0);
          seen_done  = n_done;
          seen_abort = n_abort;
        end
      endcase
    end
  end

  function automatic int model(input bit sgl, input bit odd, input int a, input int b);
    int d;
    if (sgl) return odd ? b : a;
    d = odd ? (b - a) : (a - b);
    return (d < 0) ? 0 : d;
  endfunction

  task automatic push(input int kind, input int d, input int o, input int dn, input int ab, input int c);
    exp_t e;
    e.kind = kind; e.dout = d; e.oe = o; e.done = dn; e.abrt = ab; e.cfg = c;
    q.push_back(e);
  endtask

  task automatic sck_clk(input bit d);
    din = d;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  // Master samples DOUT just before raising SCK
  task automatic data_clk(input int ed, input int eo);
    din = 1'b0;
    repeat (HALF) @(negedge clk);
    push(0, ed, eo, 0, 0, 0);
    -> chk_ev;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic frame(input bit sgl, input bit odd, input bit msbf, input int lead,
                       input int nclk, input int gap, input bit chg, input bit do_rst);
    int v, thr;
    int seq[$];
    v   = model(sgl, odd, int'(ch0), int'(ch1));
    thr = msbf ? DW : 2*DW - 1;
    seq.push_back(0);
    for (int i = DW-1; i >= 0; i--) seq.push_back(v[i]);
    if (!msbf) for (int i = 1; i < DW; i++) seq.push_back(v[i]);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    repeat (lead) sck_clk(1'b0);
    sck_clk(1'b1); sck_clk(sgl); sck_clk(odd); sck_clk(msbf);
    model_cfg = {29'd0, sgl, odd, msbf};
    if (chg) begin
      ch0 = DW'($urandom_range(0, 1023));
      ch1 = DW'($urandom_range(0, 1023));
    end
    for (int k = 0; k < nclk; k++) begin
      if (k < seq.size()) data_clk(seq[k], 1);
      else                data_clk(0, 0);
    end
    if (do_rst) begin
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      push(2, 0, 0, 0, 0, 0);
      -> chk_ev;
      rst = 1'b0;
      model_cfg = 0;
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (gap) @(negedge clk);
    push(1, 0, 0, (!do_rst && nclk >= thr) ? 1 : 0, (!do_rst && nclk < thr) ? 1 : 0, model_cfg);
    -> chk_ev;
  endtask

  initial begin
    int thr, nclk;
    bit s, o, f;
    rst = 1'b1; cs = 1'b1; sck = 1'b0; din = 1'b0; ch0 = '0; ch1 = '0;
    repeat (3) @(negedge clk);
    push(2, 0, 0, 0, 0, 0);
    -> chk_ev;
    rst = 1'b0;
    repeat (4) @(negedge clk);

    ch0 = 10'h2A5; ch1 = 10'h000;
    frame(1, 0, 1, 0, 11, 12, 0, 0);
    ch1 = 10'h3FF;
    frame(1, 1, 1, 0, 12, 12, 0, 0);
    ch0 = 10'h001;
    frame(1, 0, 0, 0, 20, 12, 0, 0);
    ch0 = 10'd100; ch1 = 10'd40;
    frame(0, 0, 1, 0, 11, 12, 0, 0);
    frame(0, 1, 1, 0, 11, 12, 0, 0);
    ch0 = 10'h2A5;
    frame(1, 0, 1, 0, 5, 12, 0, 0);
    frame(1, 0, 1, 0, 11, 12, 0, 0);
    frame(1, 0, 1, 3, 11, 12, 1, 0);
    frame(1, 1, 0, 0, 3, 12, 0, 1);
    frame(0, 0, 0, 2, 20, 12, 0, 0);

    // CS cycled with only zeros on DIN: no pulses, cfg unchanged
    cs = 1'b0;
    repeat (4) @(negedge clk);
    repeat (5) sck_clk(1'b0);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    push(1, 0, 0, 0, 0, model_cfg);
    -> chk_ev;

    // Back-to-back frames separated by a single CS-high cycle
    frame(1, 1, 1, 0, 12, 1, 0, 0);
    frame(1, 0, 1, 1, 11, 12, 0, 0);

    for (int r = 0; r < 16; r++) begin
      ch0 = DW'($urandom_range(0, 1023));
      ch1 = DW'($urandom_range(0, 1023));
      s = 1'($urandom); o = 1'($urandom); f = 1'($urandom);
      thr  = f ? DW : 2*DW - 1;
      nclk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, thr - 1) : thr + $urandom_range(0, 2);
      frame(s, o, f, $urandom_range(0, 3), nclk, 12, 1'($urandom), 0);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
